bpu_update_queue: RTL and testbench

BPU_UPDATE_QUEUE -- requirements
Module: bpu_update_queue

---
 rtl/bpu_update_queue.sv | 185 ++++++++++++++++++
 tb/tb_bpu_update_queue.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bpu_update_queue.sv
// bpu_update_queue
//
// Small FIFO that buffers branch-predictor table updates (BHT counter
// updates and BTB writes) coming from integer writeback. The head entry is
// released to the predictor only in cycles where the frontend does not own
// the table ports (pred_busy low). Each popped entry drives the upd_* outputs
// for exactly one cycle, one cycle after the pop; all other cycles upd_* is 0.
// Requests arriving while the queue is full and nothing pops are discarded
// and counted.
//
// Ports
//   clock, reset                   sole clock, synchronous active-high reset
//   intwb_bjusb_bht_*              BHT update request fields
//   intwb_bjusb_btb_*              BTB write request fields
//   pred_busy                      frontend owns predictor ports this cycle
//   upd_bht_* / upd_btb_*          registered, gated writes to the predictor
//   q_count, q_full, q_empty       occupancy status
//   drop_pulse, drop_cnt           discarded-request pulse and saturating count

`ifndef BHTBTB_INDEX_WIDTH
`define BHTBTB_INDEX_WIDTH 10
`endif

module bpu_update_queue #(
    parameter int DEPTH = 4,
    parameter int IDX_W = `BHTBTB_INDEX_WIDTH
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     intwb_bjusb_bht_write_enable,
    input  logic                     intwb_bjusb_bht_write_inc,
    input  logic                     intwb_bjusb_bht_write_dec,
    input  logic                     intwb_bjusb_bht_valid_in,
    input  logic [IDX_W-1:0]         intwb_bjusb_bht_write_index,
    input  logic [1:0]               intwb_bjusb_bht_write_counter_select,
    input  logic                     intwb_bjusb_btb_ce,
    input  logic                     intwb_bjusb_btb_we,
    input  logic [128:0]             intwb_bjusb_btb_wmask,
    input  logic [8:0]               intwb_bjusb_btb_write_index,
    input  logic [128:0]             intwb_bjusb_btb_din,
    input  logic                     pred_busy,
    output logic                     upd_bht_write_enable,
    output logic                     upd_bht_write_inc,
    output logic                     upd_bht_write_dec,
    output logic                     upd_bht_valid_in,
    output logic [IDX_W-1:0]         upd_bht_write_index,
    output logic [1:0]               upd_bht_write_counter_select,
    output logic                     upd_btb_ce,
    output logic                     upd_btb_we,
    output logic [128:0]             upd_btb_wmask,
    output logic [8:0]               upd_btb_write_index,
    output logic [128:0]             upd_btb_din,
    output logic [$clog2(DEPTH):0]   q_count,
    output logic                     q_full,
    output logic                     q_empty,
    output logic                     drop_pulse,
    output logic [15:0]              drop_cnt
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef struct packed {
        logic             bht_en;
        logic             bht_inc;
        logic             bht_dec;
        logic             bht_valid;
        logic [IDX_W-1:0] bht_index;
        logic [1:0]       bht_sel;
        logic             btb_en;
        logic [128:0]     btb_wmask;
        logic [8:0]       btb_index;
        logic [128:0]     btb_din;
    } entry_t;

    entry_t           mem [DEPTH];
    entry_t           wr_entry;
    entry_t           rd_entry;
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic             req;
    logic             do_pop;
    logic             do_enq;
    logic             do_drop;

    assign q_full  = (q_count == CNT_W'(DEPTH));
    assign q_empty = (q_count == '0);

    always_comb begin
        req     = intwb_bjusb_bht_write_enable | (intwb_bjusb_btb_ce & intwb_bjusb_btb_we);
        do_pop  = !q_empty && !pred_busy;
        // A pop frees a slot in the same cycle, so a full queue still accepts.
        do_enq  = req && (!q_full || do_pop);
        do_drop = req && q_full && !do_pop;

        wr_entry           = '0;
        wr_entry.bht_en    = intwb_bjusb_bht_write_enable;
        wr_entry.bht_inc   = intwb_bjusb_bht_write_inc;
        wr_entry.bht_dec   = intwb_bjusb_bht_write_dec;
        wr_entry.bht_valid = intwb_bjusb_bht_valid_in;
        wr_entry.bht_index = intwb_bjusb_bht_write_index;
        wr_entry.bht_sel   = intwb_bjusb_bht_write_counter_select;
        wr_entry.btb_en    = intwb_bjusb_btb_ce & intwb_bjusb_btb_we;
        wr_entry.btb_wmask = intwb_bjusb_btb_wmask;
        wr_entry.btb_index = intwb_bjusb_btb_write_index;
        wr_entry.btb_din   = intwb_bjusb_btb_din;

        rd_entry = mem[head];
    end

    // Storage carries no reset: occupancy alone decides which slots are live.
    always_ff @(posedge clock) begin
        if (do_enq) begin
            mem[tail] <= wr_entry;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            head                         <= '0;
            tail                         <= '0;
            q_count                      <= '0;
            upd_bht_write_enable         <= 1'b0;
            upd_bht_write_inc            <= 1'b0;
            upd_bht_write_dec            <= 1'b0;
            upd_bht_valid_in             <= 1'b0;
            upd_bht_write_index          <= '0;
            upd_bht_write_counter_select <= '0;
            upd_btb_ce                   <= 1'b0;
            upd_btb_we                   <= 1'b0;
            upd_btb_wmask                <= '0;
            upd_btb_write_index          <= '0;
            upd_btb_din                  <= '0;
            drop_pulse                   <= 1'b0;
            drop_cnt                     <= '0;
        end else begin
            if (do_enq) begin
                tail <= tail + PTR_W'(1);
            end
            if (do_pop) begin
                head <= head + PTR_W'(1);
            end

            case ({do_enq, do_pop})
                2'b10:   q_count <= q_count + CNT_W'(1);
                2'b01:   q_count <= q_count - CNT_W'(1);
                default: q_count <= q_count;
            endcase

            // Outputs are zero except in the cycle right after a pop, and each
            // half of the entry is masked by its own enable.
            if (do_pop) begin
                upd_bht_write_enable         <= rd_entry.bht_en;
                upd_bht_write_inc            <= rd_entry.bht_en & rd_entry.bht_inc;
                upd_bht_write_dec            <= rd_entry.bht_en & rd_entry.bht_dec;
                upd_bht_valid_in             <= rd_entry.bht_en & rd_entry.bht_valid;
                upd_bht_write_index          <= rd_entry.bht_en ? rd_entry.bht_index : '0;
                upd_bht_write_counter_select <= rd_entry.bht_en ? rd_entry.bht_sel : '0;
                upd_btb_ce                   <= rd_entry.btb_en;
                upd_btb_we                   <= rd_entry.btb_en;
                upd_btb_wmask                <= rd_entry.btb_en ? rd_entry.btb_wmask : '0;
                upd_btb_write_index          <= rd_entry.btb_en ? rd_entry.btb_index : '0;
                upd_btb_din                  <= rd_entry.btb_en ? rd_entry.btb_din : '0;
            end else begin
                upd_bht_write_enable         <= 1'b0;
                upd_bht_write_inc            <= 1'b0;
                upd_bht_write_dec            <= 1'b0;
                upd_bht_valid_in             <= 1'b0;
                upd_bht_write_index          <= '0;
                upd_bht_write_counter_select <= '0;
                upd_btb_ce                   <= 1'b0;
                upd_btb_we                   <= 1'b0;
                upd_btb_wmask                <= '0;
                upd_btb_write_index          <= '0;
                upd_btb_din                  <= '0;
            end

            drop_pulse <= do_drop;
            if (do_drop && (drop_cnt != 16'hFFFF)) begin
                drop_cnt <= drop_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_bpu_update_queue.sv
// Directed bench for bpu_update_queue: a table of per-cycle stimulus with
// hand-computed expected outputs, followed by hand-written latency and reset
// sequences.

module tb_bpu_update_queue;

    localparam int DEPTH = 4;
    localparam int IDX_W = 10;

    logic               clock = 1'b0;
    logic               reset = 1'b1;
    logic               bht_we, bht_inc, bht_dec, bht_valid;
    logic [IDX_W-1:0]   bht_idx;
    logic [1:0]         bht_sel;
    logic               btb_ce, btb_we;
    logic [128:0]       btb_wmask, btb_din;
    logic [8:0]         btb_idx;
    logic               pred_busy;
    logic               upd_bht_write_enable, upd_bht_write_inc, upd_bht_write_dec, upd_bht_valid_in;
    logic [IDX_W-1:0]   upd_bht_write_index;
    logic [1:0]         upd_bht_write_counter_select;
    logic               upd_btb_ce, upd_btb_we;
    logic [128:0]       upd_btb_wmask, upd_btb_din;
    logic [8:0]         upd_btb_write_index;
    logic [2:0]         q_count;
    logic               q_full, q_empty, drop_pulse;
    logic [15:0]        drop_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clock = ~clock;

    bpu_update_queue #(.DEPTH(DEPTH), .IDX_W(IDX_W)) dut (
        .clock                                (clock),
        .reset                                (reset),
        .intwb_bjusb_bht_write_enable         (bht_we),
        .intwb_bjusb_bht_write_inc            (bht_inc),
        .intwb_bjusb_bht_write_dec            (bht_dec),
        .intwb_bjusb_bht_valid_in             (bht_valid),
        .intwb_bjusb_bht_write_index          (bht_idx),
        .intwb_bjusb_bht_write_counter_select (bht_sel),
        .intwb_bjusb_btb_ce                   (btb_ce),
        .intwb_bjusb_btb_we                   (btb_we),
        .intwb_bjusb_btb_wmask                (btb_wmask),
        .intwb_bjusb_btb_write_index          (btb_idx),
        .intwb_bjusb_btb_din                  (btb_din),
        .pred_busy                            (pred_busy),
        .upd_bht_write_enable                 (upd_bht_write_enable),
        .upd_bht_write_inc                    (upd_bht_write_inc),
        .upd_bht_write_dec                    (upd_bht_write_dec),
        .upd_bht_valid_in                     (upd_bht_valid_in),
        .upd_bht_write_index                  (upd_bht_write_index),
        .upd_bht_write_counter_select         (upd_bht_write_counter_select),
        .upd_btb_ce                           (upd_btb_ce),
        .upd_btb_we                           (upd_btb_we),
        .upd_btb_wmask                        (upd_btb_wmask),
        .upd_btb_write_index                  (upd_btb_write_index),
        .upd_btb_din                          (upd_btb_din),
        .q_count                              (q_count),
        .q_full                               (q_full),
        .q_empty                              (q_empty),
        .drop_pulse                           (drop_pulse),
        .drop_cnt                             (drop_cnt)
    );

    // One cycle of request (or, for expectations, one popped entry).
    typedef struct packed {
        logic             bht;
        logic [IDX_W-1:0] idx;
        logic [1:0]       sel;
        logic             inc;
        logic             btb;
        logic [8:0]       bidx;
        logic             busy;
    } req_t;

    typedef struct packed {
        req_t        in;
        req_t        out;
        logic [3:0]  cnt;
        logic        drop;
        logic [15:0] dcnt;
    } vec_t;

    vec_t tbl[$];

    function automatic req_t mk(bit bht, int idx, int sel, bit inc, bit btb, int bidx, bit busy);
        req_t r;
        r.bht  = bht;
        r.idx  = bht ? IDX_W'(idx) : '0;
        r.sel  = bht ? 2'(sel) : 2'd0;
        r.inc  = bht ? inc : 1'b0;
        r.btb  = btb;
        r.bidx = btb ? 9'(bidx) : 9'd0;
        r.busy = busy;
        return r;
    endfunction

    function automatic req_t bht_r(int idx, int sel, bit inc, bit busy);
        return mk(1'b1, idx, sel, inc, 1'b0, 0, busy);
    endfunction

    function automatic req_t btb_r(int bidx, bit busy);
        return mk(1'b0, 0, 0, 1'b0, 1'b1, bidx, busy);
    endfunction

    function automatic req_t idle(bit busy);
        return mk(1'b0, 0, 0, 1'b0, 1'b0, 0, busy);
    endfunction

    task automatic add(req_t i, req_t o, int cnt, bit drop, int dcnt);
        vec_t v;
        v.in   = i;
        v.out  = o;
        v.cnt  = 4'(cnt);
        v.drop = drop;
        v.dcnt = 16'(dcnt);
        tbl.push_back(v);
    endtask

    // Fields that are not part of the request carry junk so that gating and
    // the request condition (ce without we, we without ce) are exercised.
    task automatic drive(req_t v, int r);
        bht_we    = v.bht;
        bht_inc   = v.bht ? v.inc : 1'b1;
        bht_dec   = v.bht ? !v.inc : 1'b1;
        bht_valid = 1'b1;
        bht_idx   = v.bht ? v.idx : IDX_W'(10'h2AA);
        bht_sel   = v.bht ? v.sel : 2'd3;
        if (v.btb) begin
            btb_ce  = 1'b1;
            btb_we  = 1'b1;
            btb_idx = v.bidx;
        end else begin
            btb_ce  = (r % 2 == 1);
            btb_we  = (r % 2 == 0);
            btb_idx = 9'h155;
        end
        btb_wmask = '1;
        btb_din   = '1;
        pred_busy = v.busy;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic cmp(string tag, logic [128:0] act, logic [128:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    task automatic chk(string tag, req_t e, int cnt, bit drop, int dcnt);
        cmp({tag, " bht_we"},    129'(upd_bht_write_enable), 129'(e.bht));
        cmp({tag, " bht_inc"},   129'(upd_bht_write_inc), 129'(e.inc));
        cmp({tag, " bht_dec"},   129'(upd_bht_write_dec), 129'(e.bht & !e.inc));
        cmp({tag, " bht_valid"}, 129'(upd_bht_valid_in), 129'(e.bht));
        cmp({tag, " bht_idx"},   129'(upd_bht_write_index), 129'(e.idx));
        cmp({tag, " bht_sel"},   129'(upd_bht_write_counter_select), 129'(e.sel));
        cmp({tag, " btb_ce"},    129'(upd_btb_ce), 129'(e.btb));
        cmp({tag, " btb_we"},    129'(upd_btb_we), 129'(e.btb));
        cmp({tag, " btb_idx"},   129'(upd_btb_write_index), 129'(e.bidx));
        cmp({tag, " btb_wmask"}, upd_btb_wmask, {129{e.btb}});
        cmp({tag, " btb_din"},   upd_btb_din, {129{e.btb}});
        cmp({tag, " q_count"},   129'(q_count), 129'(cnt));
        cmp({tag, " q_full"},    129'(q_full), 129'(cnt == DEPTH));
        cmp({tag, " q_empty"},   129'(q_empty), 129'(cnt == 0));
        cmp({tag, " drop_pulse"}, 129'(drop_pulse), 129'(drop));
        cmp({tag, " drop_cnt"},  129'(drop_cnt), 129'(dcnt));
    endtask

    initial begin
        req_t z, a, b, c, d, q, prev;
        z = idle(1'b0);

        // Single BHT request, two-cycle latency, then idle.
        add(bht_r(5, 2, 1'b1, 1'b0), z, 1, 1'b0, 0);
        add(idle(1'b0), bht_r(5, 2, 1'b1, 1'b0), 0, 1'b0, 0);
        add(idle(1'b0), z, 0, 1'b0, 0);

        // Six requests under backpressure: four queued, two dropped.
        a = bht_r(1, 0, 1'b0, 1'b1);
        b = btb_r(9'h011, 1'b1);
        c = bht_r(3, 1, 1'b1, 1'b1);
        d = btb_r(9'h044, 1'b1);
        add(a, z, 1, 1'b0, 0);
        add(b, z, 2, 1'b0, 0);
        add(c, z, 3, 1'b0, 0);
        add(d, z, 4, 1'b0, 0);
        add(bht_r(8, 0, 1'b0, 1'b1), z, 4, 1'b1, 1);
        add(btb_r(9'h1FF, 1'b1), z, 4, 1'b1, 2);
        add(idle(1'b1), z, 4, 1'b0, 2);
        add(idle(1'b0), a, 3, 1'b0, 2);
        add(idle(1'b0), b, 2, 1'b0, 2);
        add(idle(1'b0), c, 1, 1'b0, 2);
        add(idle(1'b0), d, 0, 1'b0, 2);
        add(idle(1'b0), z, 0, 1'b0, 2);

        // Full queue accepts a request in a pop cycle.
        add(bht_r(10, 3, 1'b0, 1'b1), z, 1, 1'b0, 2);
        add(bht_r(11, 0, 1'b1, 1'b1), z, 2, 1'b0, 2);
        add(bht_r(12, 1, 1'b0, 1'b1), z, 3, 1'b0, 2);
        add(bht_r(13, 2, 1'b1, 1'b1), z, 4, 1'b0, 2);
        add(btb_r(9'h0AB, 1'b0), bht_r(10, 3, 1'b0, 1'b0), 4, 1'b0, 2);
        add(idle(1'b0), bht_r(11, 0, 1'b1, 1'b0), 3, 1'b0, 2);
        add(idle(1'b0), bht_r(12, 1, 1'b0, 1'b0), 2, 1'b0, 2);
        add(idle(1'b0), bht_r(13, 2, 1'b1, 1'b0), 1, 1'b0, 2);
        add(idle(1'b0), btb_r(9'h0AB, 1'b0), 0, 1'b0, 2);
        add(idle(1'b0), z, 0, 1'b0, 2);

        // Ten requests with pred_busy toggling; pointers wrap more than twice.
        prev = z;
        for (int k = 0; k < 10; k++) begin
            q = mk(1'b1, 100 + k, k % 4, (k % 2) == 1, (k % 3) == 0, 256 + k, 1'b0);
            add(q, prev, 1, 1'b0, 2);
            add(idle(1'b1), z, 1, 1'b0, 2);
            prev = q;
        end
        add(idle(1'b0), prev, 0, 1'b0, 2);
        add(idle(1'b0), z, 0, 1'b0, 2);

        // Reset state.
        drive(idle(1'b0), 0);
        reset = 1'b1;
        tick();
        tick();
        chk("reset", z, 0, 1'b0, 0);
        reset = 1'b0;

        foreach (tbl[i]) begin
            drive(tbl[i].in, i);
            tick();
            chk($sformatf("row%0d", i), tbl[i].out, int'(tbl[i].cnt), tbl[i].drop, int'(tbl[i].dcnt));
        end

        // BTB request held off by pred_busy for ten cycles.
        drive(btb_r(9'h1A3, 1'b0), 0);
        tick();
        chk("btb c1", z, 1, 1'b0, 2);
        for (int cy = 1; cy <= 10; cy++) begin
            drive(idle(1'b1), cy);
            tick();
            chk($sformatf("btb c%0d", cy + 1), z, 1, 1'b0, 2);
        end
        drive(idle(1'b0), 11);
        tick();
        chk("btb c12", btb_r(9'h1A3, 1'b0), 0, 1'b0, 2);
        drive(idle(1'b0), 12);
        tick();
        chk("btb c13", z, 0, 1'b0, 2);

        // Fill the queue, then reset in a cycle that would otherwise drop.
        for (int k = 0; k < 4; k++) begin
            drive(bht_r(20 + k, k, 1'b1, 1'b1), k);
            tick();
            chk($sformatf("fill%0d", k), z, k + 1, 1'b0, 2);
        end
        drive(bht_r(30, 1, 1'b0, 1'b1), 0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mid reset", z, 0, 1'b0, 0);
        for (int k = 0; k < 3; k++) begin
            drive(idle(1'b0), k);
            tick();
            chk($sformatf("post reset%0d", k), z, 0, 1'b0, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
